table_moore_fsm: RTL

TABLE_MOORE_FSM -- requirements
Module: table_moore_fsm

---
 rtl/table_moore_fsm_pkg.sv | 23 ++
 rtl/table_moore_fsm_pri_enc.sv | 27 ++
 rtl/table_moore_fsm.sv | 113 +++++++++++
 3 files changed

// File: rtl/table_moore_fsm_pkg.sv
// Shared constants and helpers for the table-driven Moore FSM.
// Holds the default sizing, the recovery state and a width helper.
package fsm_pkg;

  localparam int NS_DEFAULT = 4;
  localparam int NQ_DEFAULT = 4;
  localparam int WW_DEFAULT = 4;
  localparam int DW_DEFAULT = 4;

  // State entered whenever the current or resolved next state is out of range.
  localparam int RECOVER_STATE = 0;

  // Bits needed to index n items, never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/table_moore_fsm_pri_enc.sv
// Lowest-set-bit priority encoder: bit 0 of the request vector wins.
// The valid flag is low when no request bit is set.
module pri_enc
  import fsm_pkg::*;
#(
  parameter int NQ = NQ_DEFAULT,
  parameter int QW = clog2(NQ)
) (
  input  logic [NQ-1:0] q,
  output logic [QW-1:0] idx,
  output logic          valid
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    idx   = '0;
    valid = 1'b0;
    // Scan from the top down so the lowest set bit is the last one written.
    for (int i = NQ - 1; i >= 0; i--) begin
      if (q[i]) begin
        idx   = QW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/table_moore_fsm.sv
// Programmable Moore FSM: next-state, output and minimum-dwell tables held in
// flip-flops, with a saturating dwell counter that gates transitions.
module table_moore_fsm
  import fsm_pkg::*;
#(
  parameter  int NS = NS_DEFAULT,
  parameter  int NQ = NQ_DEFAULT,
  parameter  int WW = WW_DEFAULT,
  parameter  int DW = DW_DEFAULT,
  localparam int SW = clog2(NS),
  localparam int QW = clog2(NQ)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [NQ-1:0] q,
  input  logic          cfg_nxt_we,
  input  logic          cfg_out_we,
  input  logic [SW-1:0] cfg_state,
  input  logic [QW-1:0] cfg_qidx,
  input  logic [SW-1:0] cfg_next,
  input  logic [WW-1:0] cfg_w,
  input  logic [DW-1:0] cfg_dwell,
  output logic [WW-1:0] w,
  output logic [SW-1:0] state_o,
  output logic          state_chg,
  output logic          dwell_busy
);

  logic [SW-1:0] nxt_tbl   [NS][NQ];
  logic [WW-1:0] out_tbl   [NS];
  logic [DW-1:0] dwell_tbl [NS];

  logic [SW-1:0] state;
  logic [DW-1:0] cnt;

  logic          state_ok;
  logic [SW-1:0] row;
  logic [QW-1:0] req_idx;
  logic          req_valid;
  logic [SW-1:0] raw_next;
  logic [SW-1:0] nxt_state;
  logic          busy;
  logic          nxt_wr_ok;
  logic          out_wr_ok;

  pri_enc #(
    .NQ (NQ),
    .QW (QW)
  ) u_pri_enc (
    .q     (q),
    .idx   (req_idx),
    .valid (req_valid)
  );

  // Out-of-range states read row 0 so table lookups never index past the arrays.
  assign state_ok  = int'(state) < NS;
  assign row       = state_ok ? state : SW'(RECOVER_STATE);
  assign busy      = state_ok && (cnt < dwell_tbl[row]);
  assign raw_next  = nxt_tbl[row][req_idx];

  assign nxt_wr_ok = cfg_nxt_we && (int'(cfg_state) < NS) && (int'(cfg_qidx) < NQ);
  assign out_wr_ok = cfg_out_we && (int'(cfg_state) < NS);

  always_comb begin
    nxt_state = state;
    if (!state_ok) begin
      nxt_state = SW'(RECOVER_STATE);
    end else if (req_valid && !busy) begin
      nxt_state = (int'(raw_next) < NS) ? raw_next : SW'(RECOVER_STATE);
    end
  end

  // Transition, dwell counter and table writes share one clocked process so a
  // synchronous reset overrides all of them together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= '0;
      cnt       <= '0;
      state_chg <= 1'b0;
      // NOTE: the tables are reset explicitly because power-up contents must be
      // self-loops with zero outputs; this also keeps them out of RAM inference.
      for (int s = 0; s < NS; s++) begin
        for (int i = 0; i < NQ; i++) begin
          nxt_tbl[s][i] <= SW'(s);
        end
        out_tbl[s]   <= '0;
        dwell_tbl[s] <= '0;
      end
    end else begin
      if (nxt_state != state) begin
        state     <= nxt_state;
        cnt       <= '0;
        state_chg <= 1'b1;
      end else begin
        state_chg <= 1'b0;
        if (cnt != '1) cnt <= cnt + 1'b1;
      end

      // Lookups above used the pre-write tables, so a write to the current row
      // only affects decisions from the next cycle on.
      if (nxt_wr_ok) nxt_tbl[cfg_state][cfg_qidx] <= cfg_next;
      if (out_wr_ok) begin
        out_tbl[cfg_state]   <= cfg_w;
        dwell_tbl[cfg_state] <= cfg_dwell;
      end
    end
  end

  assign w          = state_ok ? out_tbl[row] : '0;
  assign state_o    = state;
  assign dwell_busy = busy;

endmodule
